wvb_rd_arbiter: RTL and testbench
=================================

Name: wvb_rd_arbiter

Overview:
Round-robin readout scheduler that shares one downstream readout stream among P_N_CHAN waveform buffers, each filled by its own write controller. Picks the next channel with a pending header, pops that header, and sequences reads from the start address to the stop address of that channel's waveform RAM. Streams the samples out with a valid/ready handshake. Signals completion so the buffer space can be freed. Sits between the per-channel buffer/header FIFOs and the readout formatter.

Parameters:
P_N_CHAN, 4, number of channels arbitrated (2..16)
P_DATA_WIDTH, 22, waveform sample width
P_ADR_WIDTH, 12, waveform RAM address width
P_HDR_WIDTH, 80, header bundle width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
hdr_empty  in  P_N_CHAN  per-channel header FIFO empty (FIFO is show-ahead)
hdr_data  in  P_N_CHAN*P_HDR_WIDTH  per-channel header word at FIFO head
hdr_start_addr  in  P_N_CHAN*P_ADR_WIDTH  per-channel event start address at FIFO head
hdr_stop_addr  in  P_N_CHAN*P_ADR_WIDTH  per-channel event stop address (last written sample)
hdr_rdreq  out  P_N_CHAN  one-cycle pop of the granted channel's header FIFO
wvb_rd_addr  out  P_ADR_WIDTH  shared read address, broadcast to all RAMs
wvb_rd_en  out  P_N_CHAN  read enable of the granted RAM only
wvb_rd_data  in  P_N_CHAN*P_DATA_WIDTH  RAM read data, one cycle after wvb_rd_en
dout  out  P_DATA_WIDTH  sample
dout_hdr  out  P_HDR_WIDTH  latched header, stable for the whole event
dout_chan  out  4  granted channel index
dout_sof  out  1  first sample of the event
dout_eof  out  1  last sample of the event
dout_valid  out  1  output beat valid
dout_ready  in  1  downstream accept
rd_done  out  1  one-cycle pulse when the event is fully transferred
rd_done_chan  out  4  channel freed
rd_done_addr  out  P_ADR_WIDTH  stop_addr+1 (new read pointer for that buffer)

Behaviour:
- Reset: all outputs 0. Round-robin pointer = 0. FSM = S_IDLE. Reset mid-event abandons the event; a header that was already popped is lost; no rd_done is issued.
- Arbitration: in S_IDLE the block finds eligible channels (!hdr_empty). Grant = first eligible at or after the RR pointer, searching upward and wrapping modulo P_N_CHAN.
- Grant cycle T:
  - hdr_rdreq[grant]=1 for exactly one cycle.
  - Latch header, start address and grant.
  - len = ((stop-start) mod 2^P_ADR_WIDTH)+1, computed in P_ADR_WIDTH+1 bits, range 1..2^P_ADR_WIDTH.
  - Go to S_DATA.
- S_DATA:
  - Issue reads at wvb_rd_addr = start, start+1, … The address wraps naturally modulo 2^P_ADR_WIDTH.
  - wvb_rd_en is asserted on the granted bit only.
  - First read issues at T+1. With dout_ready held high, the first dout_valid is at T+2 and throughput is 1 sample/cycle.
- Handshake:
  - A beat transfers when dout_valid && dout_ready.
  - dout and its flags hold stable while valid && !ready.
  - dout_valid never depends combinationally on dout_ready.
  - No sample is dropped or duplicated under any ready pattern. A 2-entry skid stage is allowed.
- Flags: dout_sof is set on beat 1. dout_eof is set on beat len. Both are set together when len=1.
- Completion: after the eof beat transfers, enter S_DONE for one cycle.
  - rd_done=1; rd_done_chan=grant; rd_done_addr=stop+1 (wraps).
  - RR pointer = (grant+1) mod P_N_CHAN.
  - Return to S_IDLE. There is a one-cycle minimum gap between events.
- Headers arriving on other channels during an event wait their turn. A channel that becomes empty before its turn is skipped.
- States: S_IDLE, S_DATA, S_DONE. Illegal state returns to S_IDLE.

Optional Feature:
WVB_RD_ARB_CHAN_MASK_EN:
- Defined: adds input chan_enable[P_N_CHAN]. Eligibility becomes !hdr_empty[i] && chan_enable[i]. Clearing a bit mid-event does not abort the current event.
- Undefined: port absent; all channels are eligible.

Decomposition:
- Package wvb_rd_pkg: FSM state encodings, CHAN_IDX_WIDTH constant (4), length-computation helper function.
- One sub-module, wvb_rr_arbiter: combinational grant from request vector and pointer, plus registered pointer update on an advance strobe.

Test Plan:
- Ch2 header start=0x010 stop=0x013, ready high -> hdr_rdreq[2] at T; 4 beats on T+2..T+5 with addr 0x010..0x013; sof on beat 1, eof on beat 4; rd_done with chan=2, addr=0x014.
- Wrap: start=0xFFE stop=0x001 -> 4 beats from addrs 0xFFE,0xFFF,0x000,0x001; rd_done_addr=0x002.
- Single sample start=stop=0x123 -> one beat with sof=eof=1.
- All 4 channels pending with pointer 0 -> service order 0,1,2,3. Ch0 re-filled after its event -> serviced after ch3, not before.
- Random dout_ready (50% toggle) on a 64-sample event -> the 64 samples match the RAM model exactly in order; outputs stable while stalled.
- rst asserted at beat 10 of 32 -> next cycle all outputs 0, no rd_done. After release a pending ch1 header is granted normally.

Source files
------------

// File: rtl/wvb_rd_pkg.sv
// Shared definitions for the waveform-buffer readout arbiter: FSM states,
// channel index width and the event length helper.
package wvb_rd_pkg;

   localparam int CHAN_IDX_WIDTH = 4;
   localparam int MAX_ADR_WIDTH  = 16;
   localparam int LEN_WIDTH      = MAX_ADR_WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_DONE = 2'd2
   } rd_state_t;

   // Sample count of an event, start..stop inclusive, modulo 2^i_aw.
   function automatic logic [LEN_WIDTH-1:0] wvb_calc_len(
      input logic [MAX_ADR_WIDTH-1:0] i_start,
      input logic [MAX_ADR_WIDTH-1:0] i_stop,
      input int                       i_aw
   );
      logic [LEN_WIDTH-1:0] mask;
      mask = (LEN_WIDTH'(1) << i_aw) - LEN_WIDTH'(1);
      return (({1'b0, i_stop} - {1'b0, i_start}) & mask) + LEN_WIDTH'(1);
   endfunction

endpackage

// File: rtl/wvb_rr_arbiter.sv
// Round-robin grant: first requester at or above the pointer, wrapping.
// The pointer moves past the serviced channel on each advance strobe.
module wvb_rr_arbiter
   import wvb_rd_pkg::*;
#(
   parameter int P_N_CHAN = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [P_N_CHAN-1:0]       i_req,
   input  logic                      i_advance,
   input  logic [CHAN_IDX_WIDTH-1:0] i_adv_idx,
   output logic                      o_gnt_vld,
   output logic [CHAN_IDX_WIDTH-1:0] o_gnt_idx
);

   logic [CHAN_IDX_WIDTH-1:0] r_ptr;
   logic [2*P_N_CHAN-1:0]     w_dbl;
   logic [P_N_CHAN-1:0]       w_rot;
   int                        w_idx;

   // Rotate so bit 0 is the channel under the pointer.
   assign w_dbl = {i_req, i_req} >> r_ptr;
   assign w_rot = w_dbl[P_N_CHAN-1:0];

   always_comb begin
      o_gnt_vld = 1'b0;
      o_gnt_idx = '0;
      w_idx     = 0;
      for (int j = P_N_CHAN - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_idx = int'(r_ptr) + j;
            if (w_idx >= P_N_CHAN) w_idx = w_idx - P_N_CHAN;
            o_gnt_vld = 1'b1;
            o_gnt_idx = CHAN_IDX_WIDTH'(w_idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_ptr <= '0;
      else if (i_advance)
         r_ptr <= (i_adv_idx == CHAN_IDX_WIDTH'(P_N_CHAN - 1)) ? '0
                                                               : i_adv_idx + CHAN_IDX_WIDTH'(1);
   end

endmodule

// File: rtl/wvb_rd_arbiter.sv
// Readout scheduler: grants one channel at a time, streams its event from the
// waveform RAM through a 2-entry skid stage. Option: WVB_RD_ARB_CHAN_MASK_EN.
module wvb_rd_arbiter
   import wvb_rd_pkg::*;
#(
   parameter int P_N_CHAN     = 4,
   parameter int P_DATA_WIDTH = 22,
   parameter int P_ADR_WIDTH  = 12,
   parameter int P_HDR_WIDTH  = 80
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [P_N_CHAN-1:0]               hdr_empty,
   input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]   hdr_data,
   input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]   hdr_start_addr,
   input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]   hdr_stop_addr,
   output logic [P_N_CHAN-1:0]               hdr_rdreq,
   output logic [P_ADR_WIDTH-1:0]            wvb_rd_addr,
   output logic [P_N_CHAN-1:0]               wvb_rd_en,
   input  logic [P_N_CHAN*P_DATA_WIDTH-1:0]  wvb_rd_data,
`ifdef WVB_RD_ARB_CHAN_MASK_EN
   input  logic [P_N_CHAN-1:0]               chan_enable,
`endif
   output logic [P_DATA_WIDTH-1:0]           dout,
   output logic [P_HDR_WIDTH-1:0]            dout_hdr,
   output logic [CHAN_IDX_WIDTH-1:0]         dout_chan,
   output logic                              dout_sof,
   output logic                              dout_eof,
   output logic                              dout_valid,
   input  logic                              dout_ready,
   output logic                              rd_done,
   output logic [CHAN_IDX_WIDTH-1:0]         rd_done_chan,
   output logic [P_ADR_WIDTH-1:0]            rd_done_addr
);

   typedef struct packed {
      logic [P_DATA_WIDTH-1:0] data;
      logic                    sof;
      logic                    eof;
   } beat_t;

   rd_state_t                 r_state, w_state_nxt;
   logic [CHAN_IDX_WIDTH-1:0] r_grant, w_gnt_idx;
   logic                      w_gnt_vld, w_take, w_issue, w_xfer, w_out_vld, w_pop, w_push;
   logic [P_N_CHAN-1:0]       w_elig;
   logic [P_HDR_WIDTH-1:0]    r_hdr, w_sel_hdr;
   logic [P_ADR_WIDTH-1:0]    r_addr, r_stop, w_sel_start, w_sel_stop;
   logic [LEN_WIDTH-1:0]      r_remain, w_len;
   logic                      r_first, r_rd_vld, r_rd_sof, r_rd_eof;
   logic [1:0]                r_cnt;
   beat_t                     r_sk [2];
   beat_t                     w_in, w_out;

   logic [P_HDR_WIDTH-1:0]  w_hdr_arr   [P_N_CHAN];
   logic [P_ADR_WIDTH-1:0]  w_start_arr [P_N_CHAN];
   logic [P_ADR_WIDTH-1:0]  w_stop_arr  [P_N_CHAN];
   logic [P_DATA_WIDTH-1:0] w_rd_arr    [P_N_CHAN];

   for (genvar g = 0; g < P_N_CHAN; g++) begin : g_unpack
      assign w_hdr_arr[g]   = hdr_data[g*P_HDR_WIDTH +: P_HDR_WIDTH];
      assign w_start_arr[g] = hdr_start_addr[g*P_ADR_WIDTH +: P_ADR_WIDTH];
      assign w_stop_arr[g]  = hdr_stop_addr[g*P_ADR_WIDTH +: P_ADR_WIDTH];
      assign w_rd_arr[g]    = wvb_rd_data[g*P_DATA_WIDTH +: P_DATA_WIDTH];
   end

`ifdef WVB_RD_ARB_CHAN_MASK_EN
   assign w_elig = ~hdr_empty & chan_enable;
`else
   assign w_elig = ~hdr_empty;
`endif

   wvb_rr_arbiter #(.P_N_CHAN(P_N_CHAN)) u_rr (
      .clk       (clk),
      .rst       (rst),
      .i_req     (w_elig),
      .i_advance (r_state == S_DONE),
      .i_adv_idx (r_grant),
      .o_gnt_vld (w_gnt_vld),
      .o_gnt_idx (w_gnt_idx)
   );

   // Held off during reset so no header is popped and then discarded.
   assign w_take = (r_state == S_IDLE) && w_gnt_vld && !rst;

   always_comb begin
      w_sel_hdr   = '0;
      w_sel_start = '0;
      w_sel_stop  = '0;
      w_in        = '0;
      for (int c = 0; c < P_N_CHAN; c++) begin
         if (w_gnt_idx == CHAN_IDX_WIDTH'(c)) begin
            w_sel_hdr   = w_hdr_arr[c];
            w_sel_start = w_start_arr[c];
            w_sel_stop  = w_stop_arr[c];
         end
         if (r_grant == CHAN_IDX_WIDTH'(c)) w_in.data = w_rd_arr[c];
      end
      w_in.sof = r_rd_sof;
      w_in.eof = r_rd_eof;
   end

   assign w_len = wvb_calc_len(MAX_ADR_WIDTH'(w_sel_start), MAX_ADR_WIDTH'(w_sel_stop), P_ADR_WIDTH);

   // Skid head has priority; otherwise RAM data goes straight out.
   assign w_out_vld = (r_cnt != 2'd0) || r_rd_vld;
   assign w_out     = (r_cnt != 2'd0) ? r_sk[0] : w_in;
   assign w_xfer    = w_out_vld && dout_ready;
   assign w_pop     = (r_cnt != 2'd0) && dout_ready;
   assign w_push    = r_rd_vld && !((r_cnt == 2'd0) && dout_ready);
   // Only read when the returning sample is guaranteed a skid slot.
   assign w_issue   = (r_state == S_DATA) && (r_remain != '0) &&
                      ((r_cnt + {1'b0, r_rd_vld}) < 2'd2);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_take) w_state_nxt = S_DATA;
         S_DATA:  if (w_xfer && w_out.eof) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_hdr    <= '0;
         r_addr   <= '0;
         r_stop   <= '0;
         r_remain <= '0;
         r_first  <= 1'b0;
         r_rd_vld <= 1'b0;
         r_rd_sof <= 1'b0;
         r_rd_eof <= 1'b0;
         r_cnt    <= 2'd0;
         r_sk[0]  <= '0;
         r_sk[1]  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_take) begin
            r_grant  <= w_gnt_idx;
            r_hdr    <= w_sel_hdr;
            r_addr   <= w_sel_start;
            r_stop   <= w_sel_stop;
            r_remain <= w_len;
            r_first  <= 1'b1;
         end else if (w_issue) begin
            r_addr   <= r_addr + P_ADR_WIDTH'(1);
            r_remain <= r_remain - LEN_WIDTH'(1);
            r_first  <= 1'b0;
         end
         r_rd_vld <= w_issue;
         r_rd_sof <= w_issue && r_first;
         r_rd_eof <= w_issue && (r_remain == LEN_WIDTH'(1));
         if (w_pop) r_sk[0] <= r_sk[1];
         if (w_push) begin
            if ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop))
               r_sk[0] <= w_in;
            else
               r_sk[1] <= w_in;
         end
         r_cnt <= r_cnt - {1'b0, w_pop} + {1'b0, w_push};
      end
   end

   assign hdr_rdreq    = w_take  ? (P_N_CHAN'(1) << w_gnt_idx) : '0;
   assign wvb_rd_en    = w_issue ? (P_N_CHAN'(1) << r_grant)   : '0;
   assign wvb_rd_addr  = r_addr;
   assign dout_valid   = w_out_vld;
   assign dout         = w_out_vld ? w_out.data : '0;
   assign dout_sof     = w_out_vld && w_out.sof;
   assign dout_eof     = w_out_vld && w_out.eof;
   assign dout_hdr     = r_hdr;
   assign dout_chan    = r_grant;
   assign rd_done      = (r_state == S_DONE);
   assign rd_done_chan = rd_done ? r_grant : '0;
   assign rd_done_addr = rd_done ? r_stop + P_ADR_WIDTH'(1) : '0;

endmodule

// File: tb/tb_wvb_rd_arbiter.sv
// Directed bench for wvb_rd_arbiter: header FIFO and RAM models, beat monitor,
// hand-computed expectations for grant order, addresses, flags and completion.
module tb_wvb_rd_arbiter;

   localparam int N = 4, DW = 22, AW = 12, HW = 80;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    hdr_empty;
   logic [N*HW-1:0] hdr_data;
   logic [N*AW-1:0] hdr_start_addr, hdr_stop_addr;
   logic [N-1:0]    hdr_rdreq;
   logic [AW-1:0]   wvb_rd_addr;
   logic [N-1:0]    wvb_rd_en;
   logic [N*DW-1:0] wvb_rd_data = '0;
   logic [DW-1:0]   dout;
   logic [HW-1:0]   dout_hdr;
   logic [3:0]      dout_chan;
   logic            dout_sof, dout_eof, dout_valid;
   logic            dout_ready = 1'b1;
   logic            rd_done;
   logic [3:0]      rd_done_chan;
   logic [AW-1:0]   rd_done_addr;
`ifdef WVB_RD_ARB_CHAN_MASK_EN
   logic [N-1:0]    chan_enable = '1;
`endif

   wvb_rd_arbiter #(.P_N_CHAN(N), .P_DATA_WIDTH(DW), .P_ADR_WIDTH(AW), .P_HDR_WIDTH(HW)) dut (
      .clk(clk), .rst(rst),
      .hdr_empty(hdr_empty), .hdr_data(hdr_data),
      .hdr_start_addr(hdr_start_addr), .hdr_stop_addr(hdr_stop_addr),
      .hdr_rdreq(hdr_rdreq),
      .wvb_rd_addr(wvb_rd_addr), .wvb_rd_en(wvb_rd_en), .wvb_rd_data(wvb_rd_data),
`ifdef WVB_RD_ARB_CHAN_MASK_EN
      .chan_enable(chan_enable),
`endif
      .dout(dout), .dout_hdr(dout_hdr), .dout_chan(dout_chan),
      .dout_sof(dout_sof), .dout_eof(dout_eof),
      .dout_valid(dout_valid), .dout_ready(dout_ready),
      .rd_done(rd_done), .rd_done_chan(rd_done_chan), .rd_done_addr(rd_done_addr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // RAM model: registered read, content encodes channel and address.
   function automatic logic [DW-1:0] ram_word(input int c, input logic [AW-1:0] a);
      return {2'b10, 4'(c), 4'hA, a};
   endfunction

   always @(posedge clk)
      for (int c = 0; c < N; c++)
         if (wvb_rd_en[c]) wvb_rd_data[c*DW +: DW] <= ram_word(c, wvb_rd_addr);

   // Header FIFO models (show-ahead).
   logic [HW-1:0] hq_hdr [N][8];
   logic [AW-1:0] hq_sa  [N][8];
   logic [AW-1:0] hq_sp  [N][8];
   int            hq_wp  [N] = '{default: 0};
   int            hq_rp  [N] = '{default: 0};

   for (genvar g = 0; g < N; g++) begin : g_fifo
      assign hdr_empty[g]              = (hq_wp[g] == hq_rp[g]);
      assign hdr_data[g*HW +: HW]      = hq_hdr[g][hq_rp[g] % 8];
      assign hdr_start_addr[g*AW +: AW] = hq_sa[g][hq_rp[g] % 8];
      assign hdr_stop_addr[g*AW +: AW]  = hq_sp[g][hq_rp[g] % 8];
   end

   always @(posedge clk)
      for (int c = 0; c < N; c++)
         if (hdr_rdreq[c]) hq_rp[c] <= hq_rp[c] + 1;

   function automatic logic [HW-1:0] mk_hdr(input int c, input logic [AW-1:0] sa, input logic [AW-1:0] sp);
      return {16'hA5C3, 8'(c), 8'h00, 4'h0, sa, 4'h0, sp, 16'h1234};
   endfunction

   task automatic push_hdr(input int c, input logic [AW-1:0] sa, input logic [AW-1:0] sp);
      hq_hdr[c][hq_wp[c] % 8] = mk_hdr(c, sa, sp);
      hq_sa[c][hq_wp[c] % 8]  = sa;
      hq_sp[c][hq_wp[c] % 8]  = sp;
      hq_wp[c]++;
   endtask

   // Monitor
   typedef struct {
      int            cyc;
      int            chan;
      logic [DW-1:0] data;
      logic          sof;
      logic          eof;
      logic [HW-1:0] hdr;
   } beat_t;

   beat_t         beats[$];
   int            gnt_cyc[$], gnt_chan[$], done_cyc[$], done_chan[$];
   logic [AW-1:0] done_addr[$];
   logic          stall_q = 1'b0;
   logic [DW+1:0] hold_q  = '0;

   always @(negedge clk) begin
      if (stall_q) begin
         chk("stall_valid", 128'(dout_valid), 128'(1));
         chk("stall_hold", 128'({dout, dout_sof, dout_eof}), 128'(hold_q));
      end
      stall_q = dout_valid && !dout_ready;
      hold_q  = {dout, dout_sof, dout_eof};
      if (dout_valid && dout_ready)
         beats.push_back('{cyc: cyc, chan: int'(dout_chan), data: dout, sof: dout_sof, eof: dout_eof, hdr: dout_hdr});
      if (hdr_rdreq != '0) begin
         chk("rdreq_onehot", 128'($countones(hdr_rdreq)), 128'(1));
         for (int c = 0; c < N; c++)
            if (hdr_rdreq[c]) gnt_chan.push_back(c);
         gnt_cyc.push_back(cyc);
      end
      if (rd_done) begin
         done_cyc.push_back(cyc);
         done_chan.push_back(int'(rd_done_chan));
         done_addr.push_back(rd_done_addr);
      end
   end

   task automatic clr();
      beats.delete(); gnt_cyc.delete(); gnt_chan.delete();
      done_cyc.delete(); done_chan.delete(); done_addr.delete();
   endtask

   task automatic wait_done(input int n, input int budget, input bit rnd);
      int k = 0;
      while (done_cyc.size() < n && k < budget) begin
         @(posedge clk); #1;
         if (rnd) dout_ready = 1'($urandom_range(0, 1));
         k++;
      end
      dout_ready = 1'b1;
      chk("done_timeout", 128'(done_cyc.size() >= n), 128'(1));
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_valid"}, 128'(dout_valid), 128'(0));
      chk({nm, "_dout"}, 128'(dout), 128'(0));
      chk({nm, "_flags"}, 128'({dout_sof, dout_eof}), 128'(0));
      chk({nm, "_rdreq"}, 128'(hdr_rdreq), 128'(0));
      chk({nm, "_rden"}, 128'(wvb_rd_en), 128'(0));
      chk({nm, "_rdaddr"}, 128'(wvb_rd_addr), 128'(0));
      chk({nm, "_done"}, 128'({rd_done, rd_done_chan, rd_done_addr}), 128'(0));
      chk({nm, "_hdr"}, 128'(dout_hdr), 128'(0));
      chk({nm, "_chan"}, 128'(dout_chan), 128'(0));
   endtask

   // Checks a single event held alone in the bookkeeping queues.
   task automatic check_event(input string nm, input int c, input logic [AW-1:0] sa,
                              input logic [AW-1:0] sp, input bit timing);
      logic [AW-1:0] d, a, sp1;
      int len;
      d   = sp - sa;
      len = int'(d) + 1;
      sp1 = sp + 12'd1;
      chk({nm, "_ngnt"}, 128'(gnt_chan.size()), 128'(1));
      chk({nm, "_ndone"}, 128'(done_cyc.size()), 128'(1));
      chk({nm, "_nbeats"}, 128'(beats.size()), 128'(len));
      if (gnt_chan.size() > 0) chk({nm, "_gnt"}, 128'(gnt_chan[0]), 128'(c));
      if (done_cyc.size() > 0) begin
         chk({nm, "_done_chan"}, 128'(done_chan[0]), 128'(c));
         chk({nm, "_done_addr"}, 128'(done_addr[0]), 128'(sp1));
      end
      for (int i = 0; i < len && i < beats.size(); i++) begin
         a = sa + AW'(i);
         chk($sformatf("%s_b%0d_data", nm, i), 128'(beats[i].data), 128'(ram_word(c, a)));
         chk($sformatf("%s_b%0d_sof", nm, i), 128'(beats[i].sof), 128'(i == 0));
         chk($sformatf("%s_b%0d_eof", nm, i), 128'(beats[i].eof), 128'(i == len - 1));
         chk($sformatf("%s_b%0d_chan", nm, i), 128'(beats[i].chan), 128'(c));
         chk($sformatf("%s_b%0d_hdr", nm, i), 128'(beats[i].hdr), 128'(mk_hdr(c, sa, sp)));
         if (timing && gnt_cyc.size() > 0)
            chk($sformatf("%s_b%0d_cyc", nm, i), 128'(beats[i].cyc), 128'(gnt_cyc[0] + 2 + i));
      end
      if (timing && done_cyc.size() > 0 && beats.size() == len)
         chk({nm, "_done_cyc"}, 128'(done_cyc[0]), 128'(beats[len-1].cyc + 1));
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "global timeout");
   end

   initial begin
      int k, ndone;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1 rst = 1'b0;

      // Basic event on ch2 with cycle-exact timing.
      clr(); push_hdr(2, 12'h010, 12'h013);
      wait_done(1, 100, 1'b0);
      check_event("basic", 2, 12'h010, 12'h013, 1'b1);

      // Address wrap on ch0.
      @(posedge clk); #1 clr(); push_hdr(0, 12'hFFE, 12'h001);
      wait_done(1, 100, 1'b0);
      check_event("wrap", 0, 12'hFFE, 12'h001, 1'b1);

      // Single sample on ch1.
      @(posedge clk); #1 clr(); push_hdr(1, 12'h123, 12'h123);
      wait_done(1, 100, 1'b0);
      check_event("single", 1, 12'h123, 12'h123, 1'b1);

      // Ch3 event leaves the pointer at 0.
      @(posedge clk); #1 clr(); push_hdr(3, 12'h7F0, 12'h7F2);
      wait_done(1, 100, 1'b0);
      check_event("ch3", 3, 12'h7F0, 12'h7F2, 1'b1);

      // All four pending; ch0 refilled after its event goes last.
      @(posedge clk); #1 clr();
      for (int c = 0; c < N; c++) push_hdr(c, AW'(c * 256), AW'(c * 256 + 1));
      k = 0;
      while (done_cyc.size() < 1 && k < 100) begin @(posedge clk); #1; k++; end
      push_hdr(0, 12'h0A0, 12'h0A1);
      wait_done(5, 200, 1'b0);
      chk("rr_ngnt", 128'(gnt_chan.size()), 128'(5));
      chk("rr_nbeats", 128'(beats.size()), 128'(10));
      if (gnt_chan.size() == 5) begin
         chk("rr_o0", 128'(gnt_chan[0]), 128'(0));
         chk("rr_o1", 128'(gnt_chan[1]), 128'(1));
         chk("rr_o2", 128'(gnt_chan[2]), 128'(2));
         chk("rr_o3", 128'(gnt_chan[3]), 128'(3));
         chk("rr_o4", 128'(gnt_chan[4]), 128'(0));
         for (int i = 0; i < 4; i++)
            chk($sformatf("rr_gap%0d", i), 128'(gnt_cyc[i+1]), 128'(done_cyc[i] + 1));
      end

      // 64-sample event under random backpressure.
      @(posedge clk); #1 clr(); push_hdr(2, 12'h200, 12'h23F);
      wait_done(1, 2000, 1'b1);
      check_event("rnd", 2, 12'h200, 12'h23F, 1'b0);

      // Reset in the middle of a 32-sample event; ch1 waits behind it.
      @(posedge clk); #1 clr();
      push_hdr(3, 12'h040, 12'h05F);
      push_hdr(1, 12'h300, 12'h302);
      k = 0;
      while (beats.size() < 10 && k < 100) begin @(negedge clk); k++; end
      chk("mid_beats", 128'(beats.size() >= 10), 128'(1));
      ndone = done_cyc.size();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_zero("midrst");
      chk("midrst_nodone", 128'(done_cyc.size()), 128'(ndone));
      @(posedge clk); #1 rst = 1'b0; clr();
      wait_done(1, 100, 1'b0);
      check_event("after_rst", 1, 12'h300, 12'h302, 1'b1);

      repeat (5) @(posedge clk);
      chk("idle_tail_done", 128'(done_cyc.size()), 128'(1));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
